// File: rtl/branch_predict_unit_if.sv
// Fetch-lookup and execute-resolve bundle for branch_predict_unit.
// The statistics signals exist only when BRANCH_STATS_EN is defined.
interface branch_predict_unit_if #(
    parameter int XLEN = 32
);
    logic [XLEN-1:0] pred_pc;
    logic            pred_taken;
    logic            res_valid;
    logic [XLEN-1:0] res_pc;
    logic [XLEN-1:0] valA;
    logic [XLEN-1:0] valB;
    logic [3:0]      operacion;
    logic            res_pred;
    logic            resultado;
    logic            mispredict;
`ifdef BRANCH_STATS_EN
    logic            stats_clr;
    logic [31:0]     branch_count;
    logic [31:0]     mispredict_count;

    modport master (
        output pred_pc, res_valid, res_pc, valA, valB, operacion, res_pred, stats_clr,
        input  pred_taken, resultado, mispredict, branch_count, mispredict_count
    );
    modport slave (
        input  pred_pc, res_valid, res_pc, valA, valB, operacion, res_pred, stats_clr,
        output pred_taken, resultado, mispredict, branch_count, mispredict_count
    );
`else
    modport master (
        output pred_pc, res_valid, res_pc, valA, valB, operacion, res_pred,
        input  pred_taken, resultado, mispredict
    );
    modport slave (
        input  pred_pc, res_valid, res_pc, valA, valB, operacion, res_pred,
        output pred_taken, resultado, mispredict
    );
`endif
endinterface

// File: rtl/branch_predict_unit.sv
// Branch resolver plus a PC-indexed table of 2-bit saturating direction counters.
// Optional resolution/misprediction counters are enabled with BRANCH_STATS_EN.
module branch_predict_unit #(
    parameter int XLEN        = 32,
    parameter int BHT_ENTRIES = 64,
    parameter int IDX_LSB     = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    branch_predict_unit_if.slave bus
);
    localparam int IW = $clog2(BHT_ENTRIES);

    logic [XLEN-1:0] predPc;
    logic [XLEN-1:0] resPc;
    logic [XLEN-1:0] opA;
    logic [XLEN-1:0] opB;
    logic [IW-1:0]   predIdx;
    logic [IW-1:0]   resIdx;
    logic            outcome;
    logic            isBranch;
    logic            isCf;
    logic            unusedPcBits;

    logic [1:0] bht_q [BHT_ENTRIES];
    logic [1:0] bht_d [BHT_ENTRIES];

    assign predPc  = bus.pred_pc;
    assign resPc   = bus.res_pc;
    assign opA     = bus.valA;
    assign opB     = bus.valB;
    assign predIdx = predPc[IDX_LSB +: IW];
    assign resIdx  = resPc[IDX_LSB +: IW];
    assign unusedPcBits = ^{predPc, resPc};

    always_comb begin
        outcome  = 1'b0;
        isBranch = 1'b0;
        isCf     = 1'b0;
        case (bus.operacion)
            4'b1000: begin isBranch = 1'b1; outcome = (opA == opB); end
            4'b1001: begin isBranch = 1'b1; outcome = (opA != opB); end
            4'b1100: begin isBranch = 1'b1; outcome = ($signed(opA) <  $signed(opB)); end
            4'b1101: begin isBranch = 1'b1; outcome = ($signed(opA) >= $signed(opB)); end
            4'b1010: begin isBranch = 1'b1; outcome = (opA <  opB); end
            4'b1011: begin isBranch = 1'b1; outcome = (opA >= opB); end
            4'b1111: begin isCf = 1'b1; outcome = 1'b1; end
            default: begin end
        endcase
        isCf = isCf | isBranch;
    end

    assign bus.resultado  = outcome;
    assign bus.mispredict = bus.res_valid & isCf & (outcome != bus.res_pred);
    // Combinational read of the registered table gives read-before-write on a same-index update.
    assign bus.pred_taken = bht_q[predIdx][1];

    // Only conditional branches train; jumps carry no direction information.
    always_comb begin
        bht_d = bht_q;
        if (bus.res_valid && isBranch) begin
            if (outcome) begin
                if (bht_q[resIdx] != 2'b11) bht_d[resIdx] = bht_q[resIdx] + 2'd1;
            end else begin
                if (bht_q[resIdx] != 2'b00) bht_d[resIdx] = bht_q[resIdx] - 2'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < BHT_ENTRIES; i++) bht_q[i] <= 2'b01;
        end else begin
            bht_q <= bht_d;
        end
    end

`ifdef BRANCH_STATS_EN
    logic [31:0] branchCount_q;
    logic [31:0] branchCount_d;
    logic [31:0] mispredictCount_q;
    logic [31:0] mispredictCount_d;

    always_comb begin
        branchCount_d     = branchCount_q + {31'd0, bus.res_valid & isCf};
        mispredictCount_d = mispredictCount_q + {31'd0, bus.mispredict};
        if (bus.stats_clr) begin
            branchCount_d     = 32'd0;
            mispredictCount_d = 32'd0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            branchCount_q     <= 32'd0;
            mispredictCount_q <= 32'd0;
        end else begin
            branchCount_q     <= branchCount_d;
            mispredictCount_q <= mispredictCount_d;
        end
    end

    assign bus.branch_count     = branchCount_q;
    assign bus.mispredict_count = mispredictCount_q;
`endif
endmodule

// File: tb/tb_branch_predict_unit.sv
// Directed bench for branch_predict_unit: decode vector table plus training/collision sequences.
// Statistics checks are compiled in when BRANCH_STATS_EN is defined.
module tb_branch_predict_unit;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int total = 0;
    int bad = 0;

    branch_predict_unit_if #(.XLEN(32)) bus ();

    branch_predict_unit #(.XLEN(32), .BHT_ENTRIES(64), .IDX_LSB(2)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic        valid;
        logic        pred;
        logic        expRes;
        logic        expMis;
    } decodeVec_t;

    decodeVec_t vecs [12];

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input logic [31:0] pc, input logic [3:0] op,
                                 input logic [31:0] a, input logic [31:0] b,
                                 input logic valid, input logic pred);
        bus.res_pc    = pc;
        bus.operacion = op;
        bus.valA      = a;
        bus.valB      = b;
        bus.res_valid = valid;
        bus.res_pred  = pred;
    endtask

    task automatic idle();
        applyStimulus(32'h0, 4'b0000, 32'h0, 32'h0, 1'b0, 1'b0);
    endtask

    task automatic nextCycle();
        @(posedge clk);
        @(negedge clk);
    endtask

    logic expT [3];
    logic expN [4];
    logic expT2 [2];

    initial begin
        vecs[0]  = '{4'b1100, 32'hFFFF_FFFF, 32'h1, 1'b1, 1'b0, 1'b1, 1'b1};
        vecs[1]  = '{4'b1010, 32'hFFFF_FFFF, 32'h1, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[2]  = '{4'b1011, 32'hFFFF_FFFF, 32'h1, 1'b1, 1'b0, 1'b1, 1'b1};
        vecs[3]  = '{4'b1101, 32'hFFFF_FFFF, 32'h1, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[4]  = '{4'b1000, 32'h5,         32'h5, 1'b1, 1'b1, 1'b1, 1'b0};
        vecs[5]  = '{4'b1001, 32'h5,         32'h5, 1'b1, 1'b1, 1'b0, 1'b1};
        vecs[6]  = '{4'b1010, 32'h1, 32'hFFFF_FFFF, 1'b1, 1'b1, 1'b1, 1'b0};
        vecs[7]  = '{4'b1100, 32'h1, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[8]  = '{4'b1101, 32'h5,         32'h5, 1'b1, 1'b1, 1'b1, 1'b0};
        vecs[9]  = '{4'b1111, 32'h0,         32'h9, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[10] = '{4'b0000, 32'h5,         32'h5, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[11] = '{4'b1000, 32'h5,         32'h6, 1'b1, 1'b1, 1'b0, 1'b1};
        expT  = '{1'b1, 1'b1, 1'b1};
        expN  = '{1'b1, 1'b0, 1'b0, 1'b0};
        expT2 = '{1'b0, 1'b1};

        bus.pred_pc = 32'h0;
        idle();
`ifdef BRANCH_STATS_EN
        bus.stats_clr = 1'b0;
`endif
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 64; i++) begin
            bus.pred_pc = 32'(i) << 2;
            #1 checkOutput($sformatf("resetPred%0d", i), {31'd0, bus.pred_taken}, 32'd0);
        end

        // Decode rows train idx 15 only, which nothing below looks at.
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            applyStimulus(32'h3C, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].valid, vecs[i].pred);
            #1;
            checkOutput($sformatf("decodeRes%0d", i), {31'd0, bus.resultado}, {31'd0, vecs[i].expRes});
            checkOutput($sformatf("decodeMis%0d", i), {31'd0, bus.mispredict}, {31'd0, vecs[i].expMis});
        end
        @(negedge clk);
        idle();

        bus.pred_pc = 32'h40;
        #1 checkOutput("train40Init", {31'd0, bus.pred_taken}, 32'd0);
        for (int k = 0; k < 3; k++) begin
            applyStimulus(32'h40, 4'b1000, 32'h5, 32'h5, 1'b1, 1'b0);
            nextCycle();
            #1 checkOutput($sformatf("trainTaken%0d", k), {31'd0, bus.pred_taken}, {31'd0, expT[k]});
        end
        for (int k = 0; k < 4; k++) begin
            applyStimulus(32'h40, 4'b1001, 32'h5, 32'h5, 1'b1, 1'b1);
            nextCycle();
            #1 checkOutput($sformatf("trainNotTaken%0d", k), {31'd0, bus.pred_taken}, {31'd0, expN[k]});
        end
        for (int k = 0; k < 2; k++) begin
            applyStimulus(32'h40, 4'b1000, 32'h7, 32'h7, 1'b1, 1'b0);
            nextCycle();
            #1 checkOutput($sformatf("trainFromFloor%0d", k), {31'd0, bus.pred_taken}, {31'd0, expT2[k]});
        end
        idle();
        bus.pred_pc = 32'h140;
        #1 checkOutput("alias140", {31'd0, bus.pred_taken}, 32'd1);

        @(negedge clk);
        bus.pred_pc = 32'h80;
        applyStimulus(32'h80, 4'b1000, 32'h5, 32'h5, 1'b1, 1'b0);
        #1 checkOutput("collisionSameCycle", {31'd0, bus.pred_taken}, 32'd0);
        nextCycle();
        idle();
        #1 checkOutput("collisionNextCycle", {31'd0, bus.pred_taken}, 32'd1);

        @(negedge clk);
        bus.pred_pc = 32'hC0;
        applyStimulus(32'hC0, 4'b1111, 32'h1, 32'h2, 1'b1, 1'b0);
        #1;
        checkOutput("jumpRes", {31'd0, bus.resultado}, 32'd1);
        checkOutput("jumpMis", {31'd0, bus.mispredict}, 32'd1);
        nextCycle();
        idle();
        #1 checkOutput("jumpNoTrain", {31'd0, bus.pred_taken}, 32'd0);

        @(negedge clk);
        bus.pred_pc = 32'h80;
        applyStimulus(32'h80, 4'b0000, 32'h5, 32'h5, 1'b1, 1'b1);
        #1;
        checkOutput("unknownRes", {31'd0, bus.resultado}, 32'd0);
        checkOutput("unknownMis", {31'd0, bus.mispredict}, 32'd0);
        nextCycle();
        idle();
        #1 checkOutput("unknownNoTrain", {31'd0, bus.pred_taken}, 32'd1);

        @(negedge clk);
        #2 rst_n = 1'b0;
        #1 checkOutput("asyncResetPred", {31'd0, bus.pred_taken}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

`ifdef BRANCH_STATS_EN
        #1;
        checkOutput("statsResetBranch", bus.branch_count, 32'd0);
        checkOutput("statsResetMis", bus.mispredict_count, 32'd0);
        @(negedge clk);
        for (int k = 0; k < 10; k++) begin
            applyStimulus(32'h200 + 32'(k * 4), 4'b1000, 32'h5, 32'h5, 1'b1, (k < 3) ? 1'b0 : 1'b1);
            nextCycle();
        end
        idle();
        #1;
        checkOutput("statsBranch10", bus.branch_count, 32'd10);
        checkOutput("statsMis3", bus.mispredict_count, 32'd3);

        @(negedge clk);
        bus.stats_clr = 1'b1;
        applyStimulus(32'h200, 4'b1111, 32'h0, 32'h0, 1'b1, 1'b0);
        nextCycle();
        bus.stats_clr = 1'b0;
        idle();
        #1;
        checkOutput("statsClrBranch", bus.branch_count, 32'd0);
        checkOutput("statsClrMis", bus.mispredict_count, 32'd0);

        @(negedge clk);
        force dut.branchCount_q = 32'hFFFF_FFFF;
        #1 release dut.branchCount_q;
        checkOutput("statsPreload", bus.branch_count, 32'hFFFF_FFFF);
        applyStimulus(32'h204, 4'b1000, 32'h5, 32'h5, 1'b1, 1'b1);
        nextCycle();
        idle();
        #1 checkOutput("statsWrap", bus.branch_count, 32'd0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL timeout actual=running required=finished");
        $fatal(1, "[TB] timeout");
    end
endmodule
